// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the decoder, the issue stage and alu_32bit.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD       = 4'h0,
        ALU_SUB_SIGND = 4'h1
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_WB = 2'd1,
        FWD_EX = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decoded-instruction, writeback, forwarding and ALU-facing signals of the issue stage.
interface alu_issue_stage_if #(
    parameter int WIDTH       = alu_pkg::XLEN,
    parameter int REG_ADDR_W  = alu_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid_in;
    logic                   in_ready_out;
    logic [REG_ADDR_W-1:0]  rs1_addr_in;
    logic [REG_ADDR_W-1:0]  rs2_addr_in;
    logic [WIDTH-1:0]       rs1_data_in;
    logic [WIDTH-1:0]       rs2_data_in;
    logic [WIDTH-1:0]       imm_in;
    logic                   use_imm_in;
    logic [3:0]             alu_op_in;
    logic [REG_ADDR_W-1:0]  rd_addr_in;
    logic                   rd_we_in;
    logic [WIDTH-1:0]       alu_result_in;
    logic [REG_ADDR_W-1:0]  wb_rd_addr_in;
    logic                   wb_we_in;
    logic [WIDTH-1:0]       wb_data_in;
    logic                   flush_in;
    logic                   out_ready_in;
    logic                   valid_out;
    logic [WIDTH-1:0]       operand_a_out;
    logic [WIDTH-1:0]       operand_b_out;
    logic [3:0]             alu_operation_out;
    logic [REG_ADDR_W-1:0]  rd_addr_out;
    logic                   rd_we_out;
    logic [STALL_CNT_W-1:0] stall_cycles_out;

    modport master (
        output in_valid_in, rs1_addr_in, rs2_addr_in, rs1_data_in, rs2_data_in,
               imm_in, use_imm_in, alu_op_in, rd_addr_in, rd_we_in, alu_result_in,
               wb_rd_addr_in, wb_we_in, wb_data_in, flush_in, out_ready_in,
        input  in_ready_out, valid_out, operand_a_out, operand_b_out,
               alu_operation_out, rd_addr_out, rd_we_out, stall_cycles_out
    );

    modport slave (
        input  in_valid_in, rs1_addr_in, rs2_addr_in, rs1_data_in, rs2_data_in,
               imm_in, use_imm_in, alu_op_in, rd_addr_in, rd_we_in, alu_result_in,
               wb_rd_addr_in, wb_we_in, wb_data_in, flush_in, out_ready_in,
        output in_ready_out, valid_out, operand_a_out, operand_b_out,
               alu_operation_out, rd_addr_out, rd_we_out, stall_cycles_out
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Forwarding match and 3:1 select for one source operand; EX beats WB, x0 never forwards.
module operand_fwd_mux #(
    parameter int WIDTH      = alu_pkg::XLEN,
    parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr_in,
    input  logic [WIDTH-1:0]      rf_data_in,
    input  logic                  ex_valid_in,
    input  logic                  ex_we_in,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_in,
    input  logic [WIDTH-1:0]      ex_data_in,
    input  logic                  wb_we_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_in,
    input  logic [WIDTH-1:0]      wb_data_in,
    output logic [WIDTH-1:0]      data_out
);
    import alu_pkg::*;

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (src_addr_in != '0 && ex_valid_in && ex_we_in && src_addr_in == ex_rd_addr_in) begin
            sel = FWD_EX;
        end else if (src_addr_in != '0 && wb_we_in && src_addr_in == wb_rd_addr_in) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data_out = rf_data_in;
        case (sel)
            FWD_EX:  data_out = ex_data_in;
            FWD_WB:  data_out = wb_data_in;
            default: data_out = rf_data_in;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding alu_32bit: captures decoded instructions with forwarding resolved at capture.
module alu_issue_stage #(
    parameter int WIDTH       = alu_pkg::XLEN,
    parameter int REG_ADDR_W  = alu_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    alu_issue_stage_if.slave bus
);
    import alu_pkg::*;

    logic                   valid_q,   valid_d;
    logic [WIDTH-1:0]       op_a_q,    op_a_d;
    logic [WIDTH-1:0]       op_b_q,    op_b_d;
    logic [3:0]             alu_op_q,  alu_op_d;
    logic [REG_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic                   rd_we_q,   rd_we_d;
    logic [STALL_CNT_W-1:0] stall_q,   stall_d;

    logic             in_ready;
    logic             load;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;

    assign in_ready = !valid_q || bus.out_ready_in;
    assign load     = bus.in_valid_in && in_ready && !bus.flush_in;

    operand_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .src_addr_in   (bus.rs1_addr_in),
        .rf_data_in    (bus.rs1_data_in),
        .ex_valid_in   (valid_q),
        .ex_we_in      (rd_we_q),
        .ex_rd_addr_in (rd_addr_q),
        .ex_data_in    (bus.alu_result_in),
        .wb_we_in      (bus.wb_we_in),
        .wb_rd_addr_in (bus.wb_rd_addr_in),
        .wb_data_in    (bus.wb_data_in),
        .data_out      (fwd_rs1)
    );

    operand_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .src_addr_in   (bus.rs2_addr_in),
        .rf_data_in    (bus.rs2_data_in),
        .ex_valid_in   (valid_q),
        .ex_we_in      (rd_we_q),
        .ex_rd_addr_in (rd_addr_q),
        .ex_data_in    (bus.alu_result_in),
        .wb_we_in      (bus.wb_we_in),
        .wb_rd_addr_in (bus.wb_rd_addr_in),
        .wb_data_in    (bus.wb_data_in),
        .data_out      (fwd_rs2)
    );

    always_comb begin
        valid_d   = valid_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        alu_op_d  = alu_op_q;
        rd_addr_d = rd_addr_q;
        rd_we_d   = rd_we_q;
        stall_d   = stall_q;

        if (bus.flush_in) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            op_a_d    = fwd_rs1;
            op_b_d    = bus.use_imm_in ? bus.imm_in : fwd_rs2;
            alu_op_d  = bus.alu_op_in;
            rd_addr_d = bus.rd_addr_in;
            rd_we_d   = bus.rd_we_in;
        end else if (valid_q && bus.out_ready_in) begin
            valid_d = 1'b0;
        end

        // Saturating: stops at all-ones rather than wrapping.
        if (valid_q && !bus.out_ready_in && !bus.flush_in && stall_q != '1) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            valid_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            alu_op_q  <= ALU_ADD;
            rd_addr_q <= '0;
            rd_we_q   <= 1'b0;
            stall_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            alu_op_q  <= alu_op_d;
            rd_addr_q <= rd_addr_d;
            rd_we_q   <= rd_we_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.in_ready_out      = in_ready;
    assign bus.valid_out         = valid_q;
    assign bus.operand_a_out     = op_a_q;
    assign bus.operand_b_out     = op_b_q;
    assign bus.alu_operation_out = alu_op_q;
    assign bus.rd_addr_out       = rd_addr_q;
    assign bus.rd_we_out         = rd_we_q;
    assign bus.stall_cycles_out  = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: handshake, forwarding, immediate, stall counter, flush, reset.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic use_imm, input logic [31:0] imm,
                         input logic [3:0] op, input logic [4:0] rd, input logic we);
        bus.in_valid_in = 1'b1;
        bus.rs1_addr_in = rs1;
        bus.rs1_data_in = d1;
        bus.rs2_addr_in = rs2;
        bus.rs2_data_in = d2;
        bus.use_imm_in  = use_imm;
        bus.imm_in      = imm;
        bus.alu_op_in   = op;
        bus.rd_addr_in  = rd;
        bus.rd_we_in    = we;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.wb_we_in      = we;
        bus.wb_rd_addr_in = rd;
        bus.wb_data_in    = data;
    endtask

    initial begin
        bus.in_valid_in   = 1'b0;
        bus.rs1_addr_in   = '0;
        bus.rs2_addr_in   = '0;
        bus.rs1_data_in   = '0;
        bus.rs2_data_in   = '0;
        bus.imm_in        = '0;
        bus.use_imm_in    = 1'b0;
        bus.alu_op_in     = '0;
        bus.rd_addr_in    = '0;
        bus.rd_we_in      = 1'b0;
        bus.alu_result_in = '0;
        bus.wb_rd_addr_in = '0;
        bus.wb_we_in      = 1'b0;
        bus.wb_data_in    = '0;
        bus.flush_in      = 1'b0;
        bus.out_ready_in  = 1'b1;

        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_a", bus.operand_a_out, 32'd0);
        check("rst_b", bus.operand_b_out, 32'd0);
        check("rst_op", 32'(bus.alu_operation_out), 32'h0);
        check("rst_rd_we", 32'(bus.rd_we_out), 32'd0);
        check("rst_stall", 32'(bus.stall_cycles_out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_out), 32'd1);

        // plain load: x1=5, x2=7, ADD -> x3
        instr(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 4'h0, 5'd3, 1'b1);
        tick();
        check("load_valid", 32'(bus.valid_out), 32'd1);
        check("load_a", bus.operand_a_out, 32'd5);
        check("load_b", bus.operand_b_out, 32'd7);
        check("load_op", 32'(bus.alu_operation_out), 32'h0);
        check("load_in_ready", 32'(bus.in_ready_out), 32'd1);

        // EX forward of x3 (result 12) into SUB_SIGND
        bus.alu_result_in = 32'd12;
        instr(5'd3, 32'd0, 5'd2, 32'd7, 1'b0, 32'd0, 4'h1, 5'd5, 1'b1);
        tick();
        check("ex_fwd_a", bus.operand_a_out, 32'd12);
        check("ex_fwd_b", bus.operand_b_out, 32'd7);
        check("ex_fwd_op", 32'(bus.alu_operation_out), 32'h1);
        check("ex_fwd_rd", 32'(bus.rd_addr_out), 32'd5);

        // set up EX rd=x4
        instr(5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 4'h0, 5'd4, 1'b1);
        tick();
        check("x4_setup_a", bus.operand_a_out, 32'd0);

        // EX and WB both target x4: EX wins
        bus.alu_result_in = 32'hFFFF_FF9C;
        wb(1'b1, 5'd4, 32'd9);
        instr(5'd4, 32'h111, 5'd6, 32'd3, 1'b0, 32'd0, 4'h2, 5'd0, 1'b1);
        tick();
        check("ex_over_wb_a", bus.operand_a_out, 32'hFFFF_FF9C);
        check("ex_over_wb_b", bus.operand_b_out, 32'd3);

        // x0 never forwarded from EX (rd=x0, we=1) nor WB
        bus.alu_result_in = 32'd55;
        wb(1'b1, 5'd0, 32'd77);
        instr(5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 4'h3, 5'd7, 1'b1);
        tick();
        check("x0_a", bus.operand_a_out, 32'd0);
        check("x0_b", bus.operand_b_out, 32'd0);

        // WB forward on rs1, immediate overrides forwarded rs2
        bus.alu_result_in = 32'd0;
        wb(1'b1, 5'd9, 32'h1234);
        instr(5'd9, 32'd0, 5'd9, 32'd0, 1'b1, 32'hFFFF_FFFE, 4'h4, 5'd8, 1'b1);
        tick();
        check("wb_fwd_a", bus.operand_a_out, 32'h1234);
        check("imm_b", bus.operand_b_out, 32'hFFFF_FFFE);

        // backpressure for 4 cycles with a competing input present
        wb(1'b0, 5'd0, 32'd0);
        bus.out_ready_in = 1'b0;
        instr(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 1'b0, 32'd0, 4'h6, 5'd15, 1'b0);
        #1;
        check("bp_in_ready", 32'(bus.in_ready_out), 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("bp_valid", 32'(bus.valid_out), 32'd1);
        check("bp_a", bus.operand_a_out, 32'h1234);
        check("bp_b", bus.operand_b_out, 32'hFFFF_FFFE);
        check("bp_op", 32'(bus.alu_operation_out), 32'h4);
        check("bp_rd", 32'(bus.rd_addr_out), 32'd8);
        check("bp_stall", 32'(bus.stall_cycles_out), 32'd4);
        check("bp_in_ready_late", 32'(bus.in_ready_out), 32'd0);

        // flush with simultaneous input
        bus.flush_in = 1'b1;
        bus.out_ready_in = 1'b1;
        instr(5'd1, 32'h5555, 5'd2, 32'h6666, 1'b0, 32'd0, 4'h7, 5'd20, 1'b1);
        tick();
        check("flush_valid", 32'(bus.valid_out), 32'd0);
        check("flush_rd_we", 32'(bus.rd_we_out), 32'd0);
        check("flush_no_capture", bus.operand_a_out, 32'h1234);
        check("flush_stall", 32'(bus.stall_cycles_out), 32'd4);

        // normal load after flush
        bus.flush_in = 1'b0;
        instr(5'd10, 32'hAA, 5'd11, 32'hBB, 1'b0, 32'd0, 4'h5, 5'd12, 1'b1);
        tick();
        check("post_flush_valid", 32'(bus.valid_out), 32'd1);
        check("post_flush_a", bus.operand_a_out, 32'hAA);
        check("post_flush_b", bus.operand_b_out, 32'hBB);
        check("post_flush_op", 32'(bus.alu_operation_out), 32'h5);
        check("post_flush_rd_we", 32'(bus.rd_we_out), 32'd1);

        // drain: valid drops, data holds
        bus.in_valid_in = 1'b0;
        tick();
        check("drain_valid", 32'(bus.valid_out), 32'd0);
        check("drain_a", bus.operand_a_out, 32'hAA);

        // stale x12 not forwarded while the stage is empty
        bus.alu_result_in = 32'h999;
        instr(5'd12, 32'h5, 5'd0, 32'd0, 1'b0, 32'd0, 4'h0, 5'd13, 1'b1);
        tick();
        check("empty_no_fwd_a", bus.operand_a_out, 32'h5);

        // reset mid-stall
        bus.in_valid_in = 1'b0;
        bus.out_ready_in = 1'b0;
        tick();
        tick();
        tick();
        check("stall_before_rst", 32'(bus.stall_cycles_out), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_stall_valid", 32'(bus.valid_out), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cycles_out), 32'd0);
        check("rst_stall_op", 32'(bus.alu_operation_out), 32'h0);
        check("rst_stall_a", bus.operand_a_out, 32'd0);
        check("rst_stall_rd_we", 32'(bus.rd_we_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register directly upstream of alu_32bit.
- Captures decoded instructions and resolves operand forwarding at capture time, so the ALU sees hazard-free operands.
- Drives operand_a_in, operand_b_in and alu_operation_in of the ALU from registers.
- Uses a valid/ready handshake with flush, plus a stall-cycle counter for performance debug.

Parameters:
- WIDTH, 32, datapath width; must match alu_32bit.
- REG_ADDR_W, 5, register address width (x0..x31).
- STALL_CNT_W, 16, stall counter width.

Ports:
- clk_in  in  1  clock, rising edge.
- reset_in  in  1  synchronous, active-high reset.
- in_valid_in  in  1  decoded instruction is present.
- in_ready_out  out  1  stage can accept an instruction this cycle.
- rs1_addr_in  in  REG_ADDR_W  source register 1 index.
- rs2_addr_in  in  REG_ADDR_W  source register 2 index.
- rs1_data_in  in  WIDTH  register file value of rs1.
- rs2_data_in  in  WIDTH  register file value of rs2.
- imm_in  in  WIDTH  sign-extended immediate.
- use_imm_in  in  1  1: operand B is the immediate.
- alu_op_in  in  4  ALU operation code.
- rd_addr_in  in  REG_ADDR_W  destination register.
- rd_we_in  in  1  instruction writes rd.
- alu_result_in  in  WIDTH  combinational result_y_out of alu_32bit for the instruction currently held here.
- wb_rd_addr_in  in  REG_ADDR_W  writeback destination.
- wb_we_in  in  1  writeback is writing this cycle.
- wb_data_in  in  WIDTH  writeback data.
- flush_in  in  1  kill the held instruction and any incoming one.
- out_ready_in  in  1  downstream accepts the ALU result this cycle.
- valid_out  out  1  held instruction is valid.
- operand_a_out  out  WIDTH  to the ALU operand_a_in.
- operand_b_out  out  WIDTH  to the ALU operand_b_in.
- alu_operation_out  out  4  to the ALU alu_operation_in.
- rd_addr_out  out  REG_ADDR_W  destination of the held instruction.
- rd_we_out  out  1  write enable of the held instruction.
- stall_cycles_out  out  STALL_CNT_W  saturating stall count.

Behaviour:
- Reset (reset_in=1 at a clock edge):
  - valid_out=0, operands=0, alu_operation_out=ADD (4'h0), rd_addr_out=0, rd_we_out=0, stall_cycles_out=0.
  - Reset has priority over every other event, including reset mid-stall; the held instruction is discarded.
- Handshake (single register, no skid):
  - in_ready_out = !valid_out || out_ready_in (combinational).
  - load = in_valid_in && in_ready_out && !flush_in.
  - Latency is 1 cycle from accept to valid_out.
- Register update priority: reset > flush > load > drain > hold.
  - flush_in=1: valid_out<=0 and rd_we_out<=0 next cycle; any same-cycle input is dropped.
  - load: all output registers update and valid_out<=1. Back-to-back throughput is 1 per cycle while out_ready_in=1.
  - drain (valid_out && out_ready_in && !load): valid_out<=0; data registers hold their values.
  - hold (valid_out && !out_ready_in): all registers unchanged.
- Forwarding, evaluated per source (rs1, rs2) at load:
  - EX hit: addr != 0 && valid_out && rd_we_out && addr == rd_addr_out → use alu_result_in.
  - Else WB hit: addr != 0 && wb_we_in && addr == wb_rd_addr_in → use wb_data_in.
  - Else use rsN_data_in.
  - x0 is never forwarded.
  - EX has priority over WB when both match.
- Operand selection: operand_a_out = forwarded rs1. operand_b_out = use_imm_in ? imm_in : forwarded rs2.
- alu_op_in is passed through unmodified. Unknown codes are not checked here.
- Stall counter:
  - Increments by 1 each cycle with valid_out && !out_ready_in && !flush_in.
  - Saturates at all-ones.
  - Cleared only by reset.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ADD=4'h0, SUB_SIGND=4'h1, and further codes as added.
  - XLEN=32, REG_ADDR_W=5.
  - Shared with alu_32bit and the decoder.
- One sub-module, operand_fwd_mux: match logic plus 3:1 select for one source. Instantiated twice (rs1, rs2).

Test Plan:
- Reset mid-stall: load ADD, hold out_ready_in=0 for 3 cycles, assert reset_in → valid_out=0, stall_cycles_out=0, alu_operation_out=4'h0 next cycle.
- Plain load, no hazards: rs1=x1 (data 5), rs2=x2 (data 7), op=ADD, rd=x3, out_ready_in=1 → next cycle valid_out=1, A=5, B=7, alu_operation_out=0; in_ready_out stays 1.
- EX forward: held ADD rd=x3 with alu_result_in=12; next instruction SUB_SIGND rs1=x3 (stale rf data 0), rs2=x2=7 → A=12, B=7, op=1.
- EX over WB priority, and x0: rs1=x4 with EX rd=x4 result 0xFFFF_FF9C and WB rd=x4 data 9 → A=0xFFFF_FF9C. rs1=x0 with EX rd=x0 (we=1, result 55) → A=rs1_data_in=0.
- Immediate path and backpressure:
  - use_imm_in=1, imm=0xFFFF_FFFE, rs2 forwarded from WB → B=0xFFFF_FFFE.
  - Hold out_ready_in=0 for 4 cycles → outputs frozen, in_ready_out=0, stall_cycles_out=4.
- Flush with simultaneous input: valid_out=1, flush_in=1, in_valid_in=1 → next cycle valid_out=0, rd_we_out=0, input not captured. Following cycle, a new input loads normally.
